// File: rtl/conv_bus_mem_slave_if.sv
// Request/response bundle between the convolution unit's bus masters and the
// memory-side responder: read and write address channels, read data and write data.
interface conv_bus_mem_slave_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 28,
    parameter int ID_W   = 4
);
    logic                  arvalid;
    logic [ADDR_W-1:0]     araddr;
    logic [3:0]            arlen;
    logic [ID_W-1:0]       aruser_id;
    logic                  aruser_ap;
    logic                  arready;
    logic                  rvalid;
    logic [WIDTH-1:0]      rdata;
    logic [ID_W-1:0]       rid;
    logic                  rlast;
    logic                  awvalid;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awlen;
    logic [ID_W-1:0]       awuser_id;
    logic                  awuser_ap;
    logic                  awready;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wstrb;
    logic                  wready;
    logic [ID_W-1:0]       wuser_id;
    logic                  wuser_last;
    logic                  busy;

    modport master (
        output arvalid, araddr, arlen, aruser_id, aruser_ap,
        output awvalid, awaddr, awlen, awuser_id, awuser_ap, wdata, wstrb,
        input  arready, rvalid, rdata, rid, rlast,
        input  awready, wready, wuser_id, wuser_last, busy
    );

    modport slave (
        input  arvalid, araddr, arlen, aruser_id, aruser_ap,
        input  awvalid, awaddr, awlen, awuser_id, awuser_ap, wdata, wstrb,
        output arready, rvalid, rdata, rid, rlast,
        output awready, wready, wuser_id, wuser_last, busy
    );
endinterface

// File: rtl/conv_bus_mem_slave.sv
// Memory-side bus responder: serves one read or write burst at a time from an
// internal word-addressed store; writes win over reads when both are requested.
module conv_bus_mem_slave #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 28,
    parameter int DEPTH  = 4096,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_bus_mem_slave_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [3:0]         len_r;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic [ID_W-1:0]    id_r;
    logic               ap_r;
    logic               rvalid_r;
    logic               rlast_r;
    logic [WIDTH-1:0]   rdata_r;
    logic               wready_r;
    logic               wlast_r;
    logic               arready_s;
    logic               awready_s;
    logic               wr_beat_s;
    logic [WIDTH-1:0]   wmask_s;
    logic               unused_addr_s;

    logic [WIDTH-1:0]   mem_r [DEPTH];

    // Upper address bits beyond the memory index do not select anything.
    assign unused_addr_s = ^{bus.araddr[ADDR_W-1:IDX_W], bus.awaddr[ADDR_W-1:IDX_W]};

    // Next-state, request acceptance and per-beat address/counter arithmetic.
    always_comb begin
        state_nxt_s = state_r;
        arready_s   = 1'b0;
        awready_s   = 1'b0;
        wr_beat_s   = 1'b0;
        idx_nxt_s   = ap_r ? (idx_r + {{(IDX_W-1){1'b0}}, 1'b1}) : idx_r;
        cnt_nxt_s   = cnt_r + 4'd1;
        case (state_r)
            IDLE: begin
                awready_s = bus.awvalid & ~rst;
                arready_s = bus.arvalid & ~bus.awvalid & ~rst;
                if (awready_s) begin
                    state_nxt_s = WR_DATA;
                end else if (arready_s) begin
                    state_nxt_s = RD_ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_ADDR: state_nxt_s = RD_DATA;
            RD_DATA: begin
                if (rlast_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_DATA;
                end
            end
            WR_DATA: begin
                wr_beat_s = wready_r;
                if (wlast_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_DATA;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Expand byte strobes into a bit mask for the read-modify-write.
    always_comb begin
        wmask_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH / 8; i++) begin
            wmask_s[8*i +: 8] = {8{bus.wstrb[i]}};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst registers and registered read/write channel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r    <= {IDX_W{1'b0}};
            len_r    <= 4'd0;
            cnt_r    <= 4'd0;
            id_r     <= {ID_W{1'b0}};
            ap_r     <= 1'b0;
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            rdata_r  <= {WIDTH{1'b0}};
            wready_r <= 1'b0;
            wlast_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (awready_s) begin
                        idx_r    <= bus.awaddr[IDX_W-1:0];
                        len_r    <= bus.awlen;
                        id_r     <= bus.awuser_id;
                        ap_r     <= bus.awuser_ap;
                        cnt_r    <= 4'd0;
                        wready_r <= 1'b1;
                        wlast_r  <= (bus.awlen == 4'd0);
                    end else if (arready_s) begin
                        idx_r <= bus.araddr[IDX_W-1:0];
                        len_r <= bus.arlen;
                        id_r  <= bus.aruser_id;
                        ap_r  <= bus.aruser_ap;
                        cnt_r <= 4'd0;
                    end
                end
                RD_ADDR: begin
                    rdata_r  <= mem_r[idx_r];
                    rvalid_r <= 1'b1;
                    rlast_r  <= (cnt_r == len_r);
                    cnt_r    <= cnt_nxt_s;
                    idx_r    <= idx_nxt_s;
                end
                RD_DATA: begin
                    // cnt_r is the index of the beat being fetched, one ahead of rdata.
                    if (rlast_r) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                    end else begin
                        rdata_r <= mem_r[idx_r];
                        rlast_r <= (cnt_r == len_r);
                        cnt_r   <= cnt_nxt_s;
                        idx_r   <= idx_nxt_s;
                    end
                end
                WR_DATA: begin
                    if (wlast_r) begin
                        wready_r <= 1'b0;
                        wlast_r  <= 1'b0;
                    end else begin
                        wlast_r <= (cnt_nxt_s == len_r);
                        cnt_r   <= cnt_nxt_s;
                        idx_r   <= idx_nxt_s;
                    end
                end
                default: begin
                    rvalid_r <= 1'b0;
                    rlast_r  <= 1'b0;
                    wready_r <= 1'b0;
                    wlast_r  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: never reset, byte-masked writes.
    always_ff @(posedge clk) begin
        if (wr_beat_s) begin
            mem_r[idx_r] <= (mem_r[idx_r] & ~wmask_s) | (bus.wdata & wmask_s);
        end
    end

    assign bus.arready    = arready_s;
    assign bus.awready    = awready_s;
    assign bus.rvalid     = rvalid_r;
    assign bus.rdata      = rdata_r;
    assign bus.rlast      = rlast_r;
    assign bus.rid        = id_r;
    assign bus.wready     = wready_r;
    assign bus.wuser_last = wlast_r;
    assign bus.wuser_id   = id_r;
    assign bus.busy       = (state_r != IDLE);
endmodule

// File: tb/tb_conv_bus_mem_slave.sv
// Directed bench for conv_bus_mem_slave: burst timing, strobes, priority,
// address wrap, back-to-back requests and reset in the middle of a burst.
module tb_conv_bus_mem_slave;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] data_v [16];
    logic [3:0]  strb_v [16];
    logic [31:0] exp_v  [16];

    conv_bus_mem_slave_if #(.WIDTH(32), .ADDR_W(28), .ID_W(4)) bus ();

    conv_bus_mem_slave #(.WIDTH(32), .ADDR_W(28), .DEPTH(4096), .ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge in IDLE; ends at the negedge of the IDLE cycle after the burst.
    task automatic write_burst(input logic [27:0] addr, input logic [3:0] len,
                               input logic ap, input logic [3:0] id);
        bus.awvalid   = 1'b1;
        bus.awaddr    = addr;
        bus.awlen     = len;
        bus.awuser_ap = ap;
        bus.awuser_id = id;
        #1;
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b0) begin
            failures++;
            $display("FAIL wr_handshake: awready=%b arready=%b required 1/0", bus.awready, bus.arready);
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            bus.wdata = data_v[k];
            bus.wstrb = strb_v[k];
            checks++;
            if (bus.wready !== 1'b1 || bus.wuser_id !== id || bus.wuser_last !== (k == int'(len))
                || bus.busy !== 1'b1 || bus.arready !== 1'b0) begin
                failures++;
                $display("FAIL wr_beat%0d: wready=%b id=%h last=%b busy=%b arready=%b required 1/%h/%b/1/0",
                         k, bus.wready, bus.wuser_id, bus.wuser_last, bus.busy, bus.arready,
                         id, (k == int'(len)));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.wready !== 1'b0 || bus.wuser_last !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_end: wready=%b last=%b busy=%b required 0/0/0",
                     bus.wready, bus.wuser_last, bus.busy);
        end
    endtask

    // Called at a negedge in IDLE; ends at the negedge of the IDLE cycle after the burst.
    task automatic read_burst(input logic [27:0] addr, input logic [3:0] len,
                              input logic ap, input logic [3:0] id);
        bus.arvalid   = 1'b1;
        bus.araddr    = addr;
        bus.arlen     = len;
        bus.aruser_ap = ap;
        bus.aruser_id = id;
        #1;
        checks++;
        if (bus.arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_handshake: arready=%b required 1", bus.arready);
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency: rvalid=%b busy=%b required 0/1", bus.rvalid, bus.busy);
        end
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge clk);
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== exp_v[k] || bus.rid !== id
                || bus.rlast !== (k == int'(len))) begin
                failures++;
                $display("FAIL rd_beat%0d: rvalid=%b rdata=%h rid=%h rlast=%b required 1/%h/%h/%b",
                         k, bus.rvalid, bus.rdata, bus.rid, bus.rlast, exp_v[k], id, (k == int'(len)));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_end: rvalid=%b rlast=%b busy=%b required 0/0/0",
                     bus.rvalid, bus.rlast, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.arvalid = 1'b1;
        #12;
        checks++;
        if (bus.arready !== 1'b0 || bus.awready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rlast !== 1'b0
            || bus.wready !== 1'b0 || bus.wuser_last !== 1'b0 || bus.busy !== 1'b0
            || bus.rdata !== 32'h0 || bus.rid !== 4'h0 || bus.wuser_id !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: arready=%b awready=%b rvalid=%b rlast=%b wready=%b wlast=%b busy=%b rdata=%h rid=%h wid=%h required all 0",
                     bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.wuser_last,
                     bus.busy, bus.rdata, bus.rid, bus.wuser_id);
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read_burst();
        for (int k = 0; k < 4; k++) begin
            data_v[k] = 32'hA0 + 32'(k);
            strb_v[k] = 4'hF;
            exp_v[k]  = 32'hA0 + 32'(k);
        end
        write_burst(28'h10, 4'd3, 1'b1, 4'd5);
        read_burst(28'h10, 4'd3, 1'b1, 4'd5);
    endtask

    task automatic test_strobe();
        data_v[0] = 32'hFFFF_FFFF;
        strb_v[0] = 4'hF;
        write_burst(28'h7, 4'd0, 1'b1, 4'd1);
        data_v[0] = 32'h1234_5678;
        strb_v[0] = 4'b0101;
        write_burst(28'h7, 4'd0, 1'b1, 4'd2);
        exp_v[0] = 32'hFF34_FF78;
        read_burst(28'h7, 4'd0, 1'b1, 4'd3);
    endtask

    task automatic test_fixed_read();
        for (int k = 0; k < 3; k++) exp_v[k] = 32'hFF34_FF78;
        read_burst(28'h7, 4'd2, 1'b0, 4'd8);
    endtask

    task automatic test_priority();
        bus.arvalid   = 1'b1;
        bus.araddr    = 28'h20;
        bus.arlen     = 4'd1;
        bus.aruser_ap = 1'b1;
        bus.aruser_id = 4'd9;
        data_v[0] = 32'hC0C0_0000;
        data_v[1] = 32'hC1C1_0001;
        strb_v[0] = 4'hF;
        strb_v[1] = 4'hF;
        write_burst(28'h20, 4'd1, 1'b1, 4'd3);
        exp_v[0] = 32'hC0C0_0000;
        exp_v[1] = 32'hC1C1_0001;
        read_burst(28'h20, 4'd1, 1'b1, 4'd9);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            data_v[k] = 32'hB0 + 32'(k);
            strb_v[k] = 4'hF;
            exp_v[k]  = 32'hB0 + 32'(k);
        end
        write_burst(28'd4094, 4'd3, 1'b1, 4'd7);
        read_burst(28'd4094, 4'd3, 1'b1, 4'd7);
        exp_v[0] = 32'hB3;
        read_burst(28'h100_0001, 4'd0, 1'b1, 4'd4);
    endtask

    task automatic test_back_to_back();
        bus.arvalid   = 1'b1;
        bus.araddr    = 28'h10;
        bus.arlen     = 4'd0;
        bus.aruser_ap = 1'b1;
        bus.aruser_id = 4'd2;
        @(negedge clk);
        bus.arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rlast !== 1'b1 || bus.rdata !== 32'hA0 || bus.rid !== 4'd2) begin
            failures++;
            $display("FAIL single_beat: rvalid=%b rlast=%b rdata=%h rid=%h required 1/1/000000a0/2",
                     bus.rvalid, bus.rlast, bus.rdata, bus.rid);
        end
        bus.arvalid   = 1'b1;
        bus.araddr    = 28'h11;
        bus.aruser_id = 4'd6;
        #1;
        checks++;
        if (bus.arready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_ready: arready=%b required 0", bus.arready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_t3_ready: arready=%b rvalid=%b required 1/0", bus.arready, bus.rvalid);
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rlast !== 1'b1 || bus.rdata !== 32'hA1 || bus.rid !== 4'd6) begin
            failures++;
            $display("FAIL b2b_second: rvalid=%b rlast=%b rdata=%h rid=%h required 1/1/000000a1/6",
                     bus.rvalid, bus.rlast, bus.rdata, bus.rid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        bus.arvalid   = 1'b1;
        bus.araddr    = 28'h10;
        bus.arlen     = 4'd7;
        bus.aruser_ap = 1'b1;
        bus.aruser_id = 4'd4;
        @(negedge clk);
        bus.arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA1 || bus.rlast !== 1'b0) begin
            failures++;
            $display("FAIL mid_beat1: rvalid=%b rdata=%h rlast=%b required 1/000000a1/0",
                     bus.rvalid, bus.rdata, bus.rlast);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_drop: rvalid=%b rlast=%b busy=%b required 0/0/0",
                     bus.rvalid, bus.rlast, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_v[0] = 32'hA0;
        read_burst(28'h10, 4'd0, 1'b1, 4'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.arvalid   = 1'b0;
        bus.araddr    = 28'h0;
        bus.arlen     = 4'd0;
        bus.aruser_id = 4'd0;
        bus.aruser_ap = 1'b0;
        bus.awvalid   = 1'b0;
        bus.awaddr    = 28'h0;
        bus.awlen     = 4'd0;
        bus.awuser_id = 4'd0;
        bus.awuser_ap = 1'b0;
        bus.wdata     = 32'h0;
        bus.wstrb     = 4'h0;
        test_reset();
        test_write_read_burst();
        test_strobe();
        test_fixed_read();
        test_priority();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
